match_alert_logger: RTL and testbench

Downstream stage of the pattern-matching engine in the NIDS datapath. Consumes the matcher's per-byte match flag together with the byte-valid and packet-start strobes that fed the matcher. Tags every match with a packet ID and byte offset, and buffers the resulting alert records in a small FIFO for the host/reporting side to drain. Also keeps saturating match and drop statistics.

---
 rtl/nids_pkg.sv | 25 ++
 rtl/alert_fifo.sv | 50 +++++
 rtl/match_alert_logger.sv | 115 +++++++++++
 tb/tb_match_alert_logger.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nids_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// NIDS alert logging path.
package nids_pkg;

   localparam int OFFSET_W_DEF = 16;
   localparam int PKT_ID_W_DEF = 8;
   localparam int DEPTH_DEF    = 8;
   localparam int CNT_W_DEF    = 16;
   localparam int SAT_W_MAX    = 32;

   // Record widths are fixed at the defaults; narrower instances zero-extend.
   typedef struct packed {
      logic [PKT_ID_W_DEF-1:0] pkt_id;
      logic [OFFSET_W_DEF-1:0] offset;
   } alert_t;

   // Increment that sticks at the all-ones value of a width-bit field.
   function automatic logic [SAT_W_MAX-1:0] sat_inc(input logic [SAT_W_MAX-1:0] value,
                                                    input int width);
      logic [SAT_W_MAX-1:0] top_val;
      top_val = {SAT_W_MAX{1'b1}} >> (SAT_W_MAX - width);
      return (value >= top_val) ? value : value + SAT_W_MAX'(1);
   endfunction

endpackage

// File: rtl/alert_fifo.sv
// Show-ahead synchronous FIFO of alert records; a push while full is accepted
// only when a pop frees the head in the same cycle.
module alert_fifo
   import nids_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  alert_t push_data,
   input  logic   pop,
   output alert_t head,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   alert_t        mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head reads as zero while empty so the outputs are defined out of reset.
   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/match_alert_logger.sv
// Tags qualified matcher hits with packet ID and byte offset, queues them for
// the host, and keeps saturating match/drop statistics.
module match_alert_logger
   import nids_pkg::*;
#(
   parameter int OFFSET_W = OFFSET_W_DEF,
   parameter int PKT_ID_W = PKT_ID_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ch_valid,
   input  logic                pkt_start,
   input  logic                match_in,
   input  logic                alert_ready,
   output logic                alert_valid,
   output logic [PKT_ID_W-1:0] alert_pkt_id,
   output logic [OFFSET_W-1:0] alert_offset,
   input  logic                clear_counts,
   output logic [CNT_W-1:0]    match_count,
   output logic [CNT_W-1:0]    drop_count
);

   logic [PKT_ID_W-1:0] pkt_id;
   logic [OFFSET_W-1:0] offset;
   logic                primed;
   logic [PKT_ID_W-1:0] cur_id;
   logic [OFFSET_W-1:0] cur_off;
   logic                tag_valid;
   alert_t              tag_rec;
   alert_t              cur_rec;
   alert_t              head_rec;
   logic                qual;
   logic                pop;
   logic                full;
   logic                empty;
   logic                drop;

   // Byte position assigned to the byte presented this cycle. Until the
   // first byte after reset has been seen, a continuation byte takes offset 0.
   always_comb begin
      cur_id  = pkt_id;
      cur_off = offset;
      if (ch_valid) begin
         if (pkt_start) begin
            cur_id  = pkt_id + PKT_ID_W'(1);
            cur_off = '0;
         end else if (primed) begin
            cur_off = OFFSET_W'(sat_inc(SAT_W_MAX'(offset), OFFSET_W));
         end
      end
   end

   always_comb begin
      cur_rec        = '0;
      cur_rec.pkt_id = PKT_ID_W_DEF'(cur_id);
      cur_rec.offset = OFFSET_W_DEF'(cur_off);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_id    <= '1;
         offset    <= '0;
         primed    <= 1'b0;
         tag_valid <= 1'b0;
         tag_rec   <= '0;
      end else begin
         if (ch_valid) begin
            pkt_id <= cur_id;
            offset <= cur_off;
            primed <= 1'b1;
         end
         tag_valid <= ch_valid;
         tag_rec   <= cur_rec;
      end
   end

   assign qual = match_in & tag_valid;
   assign pop  = alert_valid & alert_ready;
   assign drop = qual & full & ~pop;

   alert_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (qual),
      .push_data(tag_rec),
      .pop      (pop),
      .head     (head_rec),
      .full     (full),
      .empty    (empty)
   );

   assign alert_valid  = ~empty;
   assign alert_pkt_id = PKT_ID_W'(head_rec.pkt_id);
   assign alert_offset = OFFSET_W'(head_rec.offset);

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clear_counts) begin
         match_count <= '0;
         drop_count  <= '0;
      end else begin
         if (qual) begin
            match_count <= CNT_W'(sat_inc(SAT_W_MAX'(match_count), CNT_W));
         end
         if (drop) begin
            drop_count <= CNT_W'(sat_inc(SAT_W_MAX'(drop_count), CNT_W));
         end
      end
   end

endmodule

// File: tb/tb_match_alert_logger.sv
// Directed bench with a cycle model and alert scoreboard for the default
// instance, plus a narrow instance for offset and counter saturation.
module tb_match_alert_logger;
   import nids_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset, ch_valid, pkt_start, match_in, alert_ready, clear_counts;
   logic        alert_valid;
   logic [7:0]  alert_pkt_id;
   logic [15:0] alert_offset;
   logic [15:0] match_count, drop_count;

   logic        rst2, cv2, ps2, m2, rdy2, clr2;
   logic        av2;
   logic [7:0]  id2;
   logic [3:0]  off2;
   logic [3:0]  mc2, dc2;

   int checks = 0;
   int errors = 0;

   alert_t q[$];
   logic [7:0]  m_id;
   logic [15:0] m_off;
   bit          m_primed;
   bit          m_tag_valid;
   alert_t      m_tag;
   logic [15:0] m_mc, m_dc;

   always #5 clk = ~clk;

   match_alert_logger #(.OFFSET_W(16), .PKT_ID_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .ch_valid(ch_valid), .pkt_start(pkt_start),
      .match_in(match_in), .alert_ready(alert_ready), .alert_valid(alert_valid),
      .alert_pkt_id(alert_pkt_id), .alert_offset(alert_offset),
      .clear_counts(clear_counts), .match_count(match_count), .drop_count(drop_count));

   match_alert_logger #(.OFFSET_W(4), .PKT_ID_W(8), .DEPTH(4), .CNT_W(4)) dut2 (
      .clk(clk), .reset(rst2), .ch_valid(cv2), .pkt_start(ps2),
      .match_in(m2), .alert_ready(rdy2), .alert_valid(av2),
      .alert_pkt_id(id2), .alert_offset(off2),
      .clear_counts(clr2), .match_count(mc2), .drop_count(dc2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Checks the DUT against the model at the falling edge, then advances the
   // model by the inputs that the next rising edge will sample.
   task automatic step();
      bit          qual;
      logic [7:0]  cid;
      logic [15:0] coff;
      @(negedge clk);
      chk("alert_valid", 32'(alert_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("head_pkt_id", 32'(alert_pkt_id), 32'(q[0].pkt_id));
         chk("head_offset", 32'(alert_offset), 32'(q[0].offset));
      end
      chk("match_count", 32'(match_count), 32'(m_mc));
      chk("drop_count", 32'(drop_count), 32'(m_dc));
      if (reset) begin
         q.delete();
         m_id = 8'hFF; m_off = 0; m_primed = 0; m_tag_valid = 0; m_tag = '0;
         m_mc = 0; m_dc = 0;
      end else begin
         qual = match_in && m_tag_valid;
         if (q.size() != 0 && alert_ready) void'(q.pop_front());
         if (qual) begin
            if (q.size() < DEPTH) q.push_back(m_tag);
            else if (m_dc != 16'hFFFF) m_dc++;
            if (m_mc != 16'hFFFF) m_mc++;
         end
         if (clear_counts) begin m_mc = 0; m_dc = 0; end
         cid = m_id; coff = m_off;
         if (ch_valid) begin
            if (pkt_start) begin cid = m_id + 8'd1; coff = 0; end
            else if (m_primed && m_off != 16'hFFFF) coff = m_off + 16'd1;
            m_id = cid; m_off = coff; m_primed = 1;
         end
         m_tag_valid = ch_valid;
         m_tag.pkt_id = cid;
         m_tag.offset = coff;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic cv, input logic ps, input logic m, input logic rdy);
      ch_valid = cv; pkt_start = ps; match_in = m; alert_ready = rdy;
      step();
   endtask

   initial begin
      reset = 1; ch_valid = 0; pkt_start = 0; match_in = 0; alert_ready = 0; clear_counts = 0;
      rst2 = 1; cv2 = 0; ps2 = 0; m2 = 0; rdy2 = 0; clr2 = 0;
      q.delete(); m_id = 8'hFF; m_off = 0; m_primed = 0; m_tag_valid = 0; m_tag = '0;
      m_mc = 0; m_dc = 0;
      @(posedge clk); #1;
      step(); step();
      reset = 0; rst2 = 0;
      chk("rst_alert_valid", 32'(alert_valid), 0);
      chk("rst_alert_pkt_id", 32'(alert_pkt_id), 0);
      chk("rst_alert_offset", 32'(alert_offset), 0);
      chk("rst_match_count", 32'(match_count), 0);

      // Single match on byte 5 of the first packet.
      cyc(1, 1, 0, 0);
      for (int i = 1; i < 8; i++) cyc(1, 0, (i == 6), 0);
      chk("single_valid", 32'(alert_valid), 1);
      chk("single_pkt_id", 32'(alert_pkt_id), 0);
      chk("single_offset", 32'(alert_offset), 5);
      chk("single_count", 32'(match_count), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

      // Two packets: match on byte 2 of the second.
      reset = 1; step(); reset = 0;
      cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      chk("two_pkt_id", 32'(alert_pkt_id), 1);
      chk("two_offset", 32'(alert_offset), 2);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

      // Back-to-back matches with the consumer always ready.
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, 1);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 1);
      chk("b2b_drops", 32'(drop_count), 0);

      // Overflow: ten matches into an eight-entry FIFO.
      reset = 1; step(); reset = 0;
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      chk("ovf_match_count", 32'(match_count), 10);
      chk("ovf_drop_count", 32'(drop_count), 2);
      chk("ovf_head_offset", 32'(alert_offset), 0);

      // Full plus pop: the new record gets in, the oldest leaves.
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 1);
      chk("fullpop_drop_count", 32'(drop_count), 2);
      chk("fullpop_match_count", 32'(match_count), 11);
      chk("fullpop_head_offset", 32'(alert_offset), 1);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);
      chk("fullpop_drained", 32'(alert_valid), 0);

      // Unqualified match_in is ignored.
      reset = 1; step(); reset = 0;
      cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
      chk("unqual_valid", 32'(alert_valid), 0);
      chk("unqual_count", 32'(match_count), 0);

      // Reset with alerts queued; a match right after reset is dropped silently.
      cyc(1, 1, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      chk("queued_count", 32'(match_count), 3);
      ch_valid = 1; pkt_start = 0; match_in = 0; reset = 1; step(); reset = 0;
      chk("rst_mid_valid", 32'(alert_valid), 0);
      chk("rst_mid_count", 32'(match_count), 0);
      cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
      chk("post_rst_valid", 32'(alert_valid), 0);
      chk("post_rst_count", 32'(match_count), 0);

      // Clear coincident with a match.
      cyc(1, 1, 0, 1); cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
      chk("pre_clear_count", 32'(match_count), 1);
      clear_counts = 1; cyc(0, 0, 1, 1); clear_counts = 0;
      chk("clear_count", 32'(match_count), 0);
      cyc(0, 0, 0, 1);

      // Narrow instance: offset saturates at 15.
      cv2 = 1; ps2 = 1; step(); ps2 = 0;
      for (int i = 1; i < 20; i++) begin
         m2 = (i == 18);
         step();
      end
      cv2 = 0; m2 = 1; step(); m2 = 0; step();
      chk("sat_off_valid", 32'(av2), 1);
      chk("sat_off_pkt_id", 32'(id2), 0);
      chk("sat_off_offset", 32'(off2), 15);
      chk("sat_off_count", 32'(mc2), 2);
      rdy2 = 1; step();
      chk("sat_off_offset2", 32'(off2), 15);
      cv2 = 1; m2 = 1;
      for (int i = 0; i < 20; i++) step();
      cv2 = 0; m2 = 0; step();
      chk("sat_cnt_match", 32'(mc2), 15);
      chk("sat_cnt_drop", 32'(dc2), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
